serial_mantissa_adder: RTL and testbench
========================================

// Module: serial_mantissa_adder
// PURPOSE
//  Bit-serial add/subtract unit for the FP ALU mantissa datapath: LSB-first, one bit per clock.
//  Drives a single full_adder cell and registers its carry between cycles.
//  Sits after exponent alignment and before normalisation; trades W cycles of latency for minimal area.
// PARAMETERS
//  W   24   operand/result width in bits (mantissa incl. hidden bit); legal range W >= 2
// PORTS
//  clk     in   1   single clock, rising edge
//  rst_n   in   1   synchronous reset, active-low
//  start   in   1   request; sampled only in IDLE
//  sub     in   1   0 = a+b, 1 = a-b; sampled with start
//  a       in   W   operand A; sampled with start
//  b       in   W   operand B; sampled with start
//  busy    out  1   high in RUN and DONE
//  done    out  1   one-cycle pulse; result/c_out/ovf valid from this cycle
//  result  out  W   sum/difference, two's complement, modulo 2^W
//  c_out   out  1   final carry; in sub mode 1 = no borrow (a >= b unsigned)
//  ovf     out  1   signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Reset (rst_n=0 at a rising edge): state=IDLE; busy, done, result, c_out, ovf, counter, carry all 0.
//  Reset has priority over every other event and aborts an operation mid-RUN; no done is produced.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on start=1, load a_sh=a, b_sh=(sub ? ~b : b), carry=sub, cnt=0, clear result -> RUN.
//     Outputs result/c_out/ovf keep their last values until the load edge.
//   RUN: each edge, full_adder(a_sh[0], b_sh[0], carry) gives {co,s}.
//     Shift a_sh, b_sh right by 1; result <= {s, result[W-1:1]}; carry <= co; cnt++.
//     When cnt==W-1 (MSB bit): also ovf <= carry ^ co; c_out <= co; go to DONE.
//   DONE: done=1 for exactly one cycle; go to IDLE unconditionally.
//  Latency: start sampled at edge 0; W RUN edges (1..W); done high after edge W+1.
//   Next start is accepted at edge W+2 at the earliest.
//  start while busy (RUN or DONE) is ignored; operand and sub changes while busy have no effect.
//  Results hold stable after done until the next accepted start.
//  result must not be sampled before done; partial values are visible during RUN.
//  cnt width = $clog2(W); no wrap is reachable since RUN exits at W-1.
//  W=24 worst case: carry chain is one cell; all ops are purely registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared include fpalu_defs.vh:
//   state encodings (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2);
//   default mantissa width FP_MANT_W=24 (used for W).
//  Exactly one sub-module instance: full_adder (c_out, sum, a, b, c_in) from the existing library.
//  Everything else is local: FSM, shift registers, counter, carry/ovf flops.
// TESTING
//  1 add a=24'h000001 b=24'h000001 -> result=24'h000002, c_out=0, ovf=0; done exactly 25 clks after start edge.
//  2 add a=24'hFFFFFF b=24'h000001 -> result=24'h000000, c_out=1, ovf=0.
//  3 sub a=24'h000005 b=24'h000007 -> result=24'hFFFFFE, c_out=0 (borrow); sub a=7 b=5 -> result=2, c_out=1.
//  4 add a=24'h7FFFFF b=24'h000001 -> result=24'h800000, ovf=1, c_out=0.
//  5 start a=3,b=4, then start=1 with a=100 every cycle of RUN -> one done, result=7.
//    busy=0 after DONE; next start accepted.
//  6 rst_n=0 for one edge at RUN bit 10 -> busy, done, result, c_out, ovf all 0 on the next cycle, no done pulse;
//    a fresh add 9+6 then gives 15.

Source files
------------

// File: rtl/serial_mantissa_adder_pkg.sv
// Shared definitions for the bit-serial mantissa add/subtract unit:
// FSM state encodings and the default mantissa width.
package serial_mantissa_adder_pkg;

    // Default mantissa width, hidden bit included.
    localparam int FP_MANT_W = 24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared library primitive.
module full_adder (
    output logic c_out,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic c_in
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_mantissa_adder.sv
// Bit-serial mantissa add/subtract, LSB first, one bit per clock.
// Subtraction is a + ~b + 1: b is inverted at load and the carry is
// preset to 1. One full_adder cell is reused on every RUN cycle.
module serial_mantissa_adder
    import serial_mantissa_adder_pkg::*;
#(
    parameter int W = FP_MANT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         c_out,
    output logic         ovf
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t state, state_nxt;

    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     result_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             done_q;
    logic             c_out_q;
    logic             ovf_q;

    logic             load;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_co;

    full_adder u_fa (
        .c_out (fa_co),
        .sum   (fa_sum),
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus load / last-bit strobes and busy flag.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last_bit  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    last_bit  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Serial datapath: operand shifters, result shifter, carry, flags.
    // The done pulse is registered on the DONE->IDLE edge so that every
    // output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            result_q <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            done_q   <= 1'b0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= (state == S_DONE);
            if (load) begin
                a_sh     <= a;
                b_sh     <= sub ? ~b : b;
                carry    <= sub;
                cnt      <= '0;
                result_q <= '0;
            end else if (state == S_RUN) begin
                a_sh     <= a_sh >> 1;
                b_sh     <= b_sh >> 1;
                result_q <= {fa_sum, result_q[W-1:1]};
                carry    <= fa_co;
                cnt      <= cnt + 1'b1;
                if (last_bit) begin
                    // carry holds the carry into the MSB at this point.
                    ovf_q   <= carry ^ fa_co;
                    c_out_q <= fa_co;
                end
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign c_out  = c_out_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_mantissa_adder.sv
// Scoreboard bench for serial_mantissa_adder: stimulus pushes expected
// results into a queue, a monitor pops and compares on every done pulse.
module tb_serial_mantissa_adder;

    localparam int W = 24;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         ovf;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    serial_mantissa_adder #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint ux, uy, sx, sy, u, sv;
        longint modv, smax, smin;
        modv = 64'sd1 << W;
        smax = (64'sd1 << (W - 1)) - 1;
        smin = -(64'sd1 << (W - 1));
        ux = longint'(x);
        uy = longint'(y);
        sx = x[W-1] ? ux - modv : ux;
        sy = y[W-1] ? uy - modv : uy;
        u  = s ? ux - uy : ux + uy;
        sv = s ? sx - sy : sx + sy;
        e.r = W'(u & (modv - 1));
        e.c = s ? (ux >= uy) : (u >= modv);
        e.v = (sv > smax) || (sv < smin);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = q.pop_front();
                check("result", 64'(result), 64'(e.r));
                check("c_out",  64'(c_out),  64'(e.c));
                check("ovf",    64'(ovf),    64'(e.v));
            end
        end
    end

    // Issue one operation and wait for its done pulse. With hold set,
    // start stays high and operands keep changing throughout the busy period.
    task automatic run_op(input bit s, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
        int   k;
        bit   seen;
        exp_t e;
        e = model(s, x, y);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        q.push_back(e);
        @(posedge clk);
        k    = 0;
        seen = 0;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("busy_run", 64'(busy), 64'd1);
        while (!seen && k < 100) begin
            if (hold) begin
                a   = W'(100);
                b   = W'($urandom);
                sub = 1'($urandom);
            end
            @(posedge clk);
            k++;
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        start = 1'b0;
        check("latency", 64'(k), 64'(W + 1));
        check("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        a   = $urandom;
        b   = $urandom;
        sub = $urandom;
        repeat (2) @(negedge clk);
        check("result_hold", 64'(result), 64'(e.r));
        check("c_out_hold",  64'(c_out),  64'(e.c));
        check("ovf_hold",    64'(ovf),    64'(e.v));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   64'(busy),   64'd0);
        check("rst_done",   64'(done),   64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_c_out",  64'(c_out),  64'd0);
        check("rst_ovf",    64'(ovf),    64'd0);
        rst_n = 1'b1;

        // Directed cases.
        run_op(1'b0, 24'h000001, 24'h000001, 1'b0);
        run_op(1'b0, 24'hFFFFFF, 24'h000001, 1'b0);
        run_op(1'b1, 24'h000005, 24'h000007, 1'b0);
        run_op(1'b1, 24'h000007, 24'h000005, 1'b0);
        run_op(1'b0, 24'h7FFFFF, 24'h000001, 1'b0);
        run_op(1'b1, 24'h800000, 24'h000001, 1'b0);
        run_op(1'b1, 24'h123456, 24'h123456, 1'b0);

        // start and operands held/changing while busy must be ignored.
        run_op(1'b0, 24'd3, 24'd4, 1'b1);
        run_op(1'b0, 24'd10, 24'd20, 1'b0);

        // Reset mid-RUN: abort, everything cleared, no done pulse.
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        a     = 24'h0ABCDE;
        b     = 24'h012345;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy",   64'(busy),   64'd0);
        check("abort_done",   64'(done),   64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_c_out",  64'(c_out),  64'd0);
        check("abort_ovf",    64'(ovf),    64'd0);
        repeat (30) @(negedge clk);
        run_op(1'b0, 24'd9, 24'd6, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
